// File: rtl/bfly01_feeder.sv
// bfly01_feeder: pairs x[n] with x[n+256] for a radix-2 first-stage butterfly.
//
// A 512-point frame arrives as 32 blocks of 16 lanes. Blocks 0..15 (FILL) are
// parked in a 16-row buffer. Each of blocks 16..31 (PAIR) is sent out as lane b,
// together with the buffered row (blk-16) as lane a, one cycle after acceptance.
//
// Ports:
//   clk, rstn                  clock, async active-low reset
//   din_valid                  a 16-lane input block is present this cycle
//   din_real/din_imag [15:0]   16 lanes x signed VEC_W
//   frame_clr                  synchronous frame abort (beats din_valid)
//   valid_in                   one-cycle pulse per emitted pair block
//   base_input_idx [8:0]       16*(blk-16) of the emitted pair block
//   input_{real,imag}_{a,b}    16 lanes x signed VEC_W, held while valid_in=0
//   frame_done                 pulses together with the last pair block
//   frame_cnt [7:0]            only with BFLY01_FEEDER_FRAME_CNT_EN defined:
//                              counts frame_done pulses, wraps 255->0
//
// Optional feature macro: BFLY01_FEEDER_FRAME_CNT_EN.

// One lane: its column of the FILL buffer plus its registered a/b outputs.
module bfly01_feeder_lane #(
  parameter int VEC_W = 10
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en,
  input  logic             emit,
  input  logic [3:0]       row,
  input  logic [VEC_W-1:0] din_re,
  input  logic [VEC_W-1:0] din_im,
  output logic [VEC_W-1:0] a_re,
  output logic [VEC_W-1:0] a_im,
  output logic [VEC_W-1:0] b_re,
  output logic [VEC_W-1:0] b_im
);
  // Buffer is deliberately not reset: every row is rewritten during FILL
  // before PAIR reads it.
  logic [VEC_W-1:0] re_mem [16];
  logic [VEC_W-1:0] im_mem [16];

  logic [VEC_W-1:0] a_re_q, a_im_q, b_re_q, b_im_q;
  logic [VEC_W-1:0] a_re_d, a_im_d, b_re_d, b_im_d;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      re_mem[row] <= din_re;
      im_mem[row] <= din_im;
    end
  end

  // Outputs only move on an emission; otherwise they hold.
  always_comb begin
    a_re_d = a_re_q;
    a_im_d = a_im_q;
    b_re_d = b_re_q;
    b_im_d = b_im_q;
    if (emit) begin
      a_re_d = re_mem[row];
      a_im_d = im_mem[row];
      b_re_d = din_re;
      b_im_d = din_im;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_re_q <= '0;
      a_im_q <= '0;
      b_re_q <= '0;
      b_im_q <= '0;
    end else begin
      a_re_q <= a_re_d;
      a_im_q <= a_im_d;
      b_re_q <= b_re_d;
      b_im_q <= b_im_d;
    end
  end

  assign a_re = a_re_q;
  assign a_im = a_im_q;
  assign b_re = b_re_q;
  assign b_im = b_im_q;
endmodule

module bfly01_feeder #(
  parameter int VEC_W = 10
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         din_valid,
  input  logic signed [15:0][VEC_W-1:0] din_real,
  input  logic signed [15:0][VEC_W-1:0] din_imag,
  input  logic                         frame_clr,
  output logic                         valid_in,
  output logic [8:0]                   base_input_idx,
  output logic signed [15:0][VEC_W-1:0] input_real_a,
  output logic signed [15:0][VEC_W-1:0] input_imag_a,
  output logic signed [15:0][VEC_W-1:0] input_real_b,
  output logic signed [15:0][VEC_W-1:0] input_imag_b,
  output logic                         frame_done
`ifdef BFLY01_FEEDER_FRAME_CNT_EN
  ,
  output logic [7:0]                   frame_cnt
`endif
);
  // Frame geometry (16 rows x 16 lanes, 9-bit point index) is fixed at 16 lanes.
  localparam int NUM_LANES = 16;

  logic [4:0] blk_cnt_q, blk_cnt_d;
  logic [8:0] base_q, base_d;
  logic       valid_in_q, valid_in_d;
  logic       frame_done_q, frame_done_d;
  logic       accept, fill_wr, emit;

  // blk_cnt[4] selects the phase: 0 = FILL, 1 = PAIR; blk_cnt[3:0] is the row.
  always_comb begin
    accept       = din_valid & ~frame_clr;
    fill_wr      = accept & ~blk_cnt_q[4];
    emit         = accept & blk_cnt_q[4];
    blk_cnt_d    = blk_cnt_q;
    if (frame_clr)   blk_cnt_d = '0;
    else if (accept) blk_cnt_d = blk_cnt_q + 5'd1;  // 31 wraps to 0: next frame
    valid_in_d   = emit;
    frame_done_d = emit & (&blk_cnt_q);
    base_d       = emit ? {1'b0, blk_cnt_q[3:0], 4'b0000} : base_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      blk_cnt_q    <= '0;
      base_q       <= '0;
      valid_in_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      blk_cnt_q    <= blk_cnt_d;
      base_q       <= base_d;
      valid_in_q   <= valid_in_d;
      frame_done_q <= frame_done_d;
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    bfly01_feeder_lane #(.VEC_W(VEC_W)) u_lane (
      .clk    (clk),
      .rstn   (rstn),
      .wr_en  (fill_wr),
      .emit   (emit),
      .row    (blk_cnt_q[3:0]),
      .din_re (din_real[l]),
      .din_im (din_imag[l]),
      .a_re   (input_real_a[l]),
      .a_im   (input_imag_a[l]),
      .b_re   (input_real_b[l]),
      .b_im   (input_imag_b[l])
    );
  end

  assign valid_in       = valid_in_q;
  assign frame_done     = frame_done_q;
  assign base_input_idx = base_q;

`ifdef BFLY01_FEEDER_FRAME_CNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;

  // Counts on the same edge that raises frame_done; frame_clr leaves it alone.
  always_comb frame_cnt_d = frame_cnt_q + {7'd0, frame_done_d};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) frame_cnt_q <= '0;
    else       frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`endif
endmodule

// File: tb/tb_bfly01_feeder.sv
// Directed bench for bfly01_feeder: one scenario task per feature, inputs
// driven on the falling edge, outputs sampled on the next falling edge.
module tb_bfly01_feeder;
  logic clk = 1'b0;
  logic rstn;
  logic din_valid;
  logic frame_clr;
  logic signed [15:0][9:0] din_real, din_imag;
  logic        valid_in;
  logic [8:0]  base_input_idx;
  logic signed [15:0][9:0] input_real_a, input_imag_a, input_real_b, input_imag_b;
  logic        frame_done;
`ifdef BFLY01_FEEDER_FRAME_CNT_EN
  logic [7:0]  frame_cnt;
`endif

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bfly01_feeder dut (
    .clk            (clk),
    .rstn           (rstn),
    .din_valid      (din_valid),
    .din_real       (din_real),
    .din_imag       (din_imag),
    .frame_clr      (frame_clr),
    .valid_in       (valid_in),
    .base_input_idx (base_input_idx),
    .input_real_a   (input_real_a),
    .input_imag_a   (input_imag_a),
    .input_real_b   (input_real_b),
    .input_imag_b   (input_imag_b),
    .frame_done     (frame_done)
`ifdef BFLY01_FEEDER_FRAME_CNT_EN
    ,
    .frame_cnt      (frame_cnt)
`endif
  );

  // 10-bit two's-complement truncation of a point value.
  function automatic logic [9:0] t10(input int v);
    logic [31:0] w;
    w = v;
    return w[9:0];
  endfunction

  // Block whose lane i carries point (pt0+i): real = point, imag = -point.
  task automatic set_blk(input int pt0);
    for (int i = 0; i < 16; i++) begin
      din_real[i] = t10(pt0 + i);
      din_imag[i] = t10(-(pt0 + i));
    end
  endtask

  // One clock: inputs applied now, outputs of that edge visible on return.
  task automatic step(input logic v, input logic clr);
    din_valid = v;
    frame_clr = clr;
    @(negedge clk);
    din_valid = 1'b0;
    frame_clr = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0; din_valid = 1'b0; frame_clr = 1'b0;
    set_blk(0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (valid_in !== 1'b0 || frame_done !== 1'b0 || base_input_idx !== 9'd0) begin
      errs++;
      $display("FAIL reset_ctrl valid_in=%0b frame_done=%0b base=%0d required 0/0/0",
               valid_in, frame_done, base_input_idx);
    end
    checks++;
    if (input_real_a !== '0 || input_imag_a !== '0 || input_real_b !== '0 || input_imag_b !== '0) begin
      errs++;
      $display("FAIL reset_data a_re=%h b_re=%h required all zero", input_real_a, input_real_b);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // One full frame of 32 blocks with point offset off; gap inserts an idle
  // cycle after each block. Assumes the block counter is at 0 on entry.
  task automatic test_frame(input string tag, input int off, input bit gap);
    logic [9:0] ea, eb, eai, ebi;
    for (int b = 0; b < 32; b++) begin
      set_blk(16 * b + off);
      step(1'b1, 1'b0);
      checks++;
      if (valid_in !== (b >= 16)) begin
        errs++;
        $display("FAIL %s valid blk%0d got %0b required %0b", tag, b, valid_in, b >= 16);
      end
      checks++;
      if (frame_done !== (b == 31)) begin
        errs++;
        $display("FAIL %s frame_done blk%0d got %0b required %0b", tag, b, frame_done, b == 31);
      end
      if (b >= 16) begin
        checks++;
        if (base_input_idx !== 9'(16 * (b - 16))) begin
          errs++;
          $display("FAIL %s base blk%0d got %0d required %0d", tag, b, base_input_idx, 16 * (b - 16));
        end
        for (int i = 0; i < 16; i++) begin
          ea  = t10(16 * (b - 16) + off + i);
          eai = t10(-(16 * (b - 16) + off + i));
          eb  = t10(16 * b + off + i);
          ebi = t10(-(16 * b + off + i));
          checks++;
          if (input_real_a[i] !== ea || input_imag_a[i] !== eai ||
              input_real_b[i] !== eb || input_imag_b[i] !== ebi) begin
            errs++;
            $display("FAIL %s lane blk%0d l%0d a=%0d/%0d b=%0d/%0d required %0d/%0d %0d/%0d",
                     tag, b, i, input_real_a[i], input_imag_a[i], input_real_b[i], input_imag_b[i],
                     $signed(ea), $signed(eai), $signed(eb), $signed(ebi));
          end
        end
      end
      if (gap) begin
        set_blk(999);
        step(1'b0, 1'b0);
        checks++;
        if (valid_in !== 1'b0 || frame_done !== 1'b0) begin
          errs++;
          $display("FAIL %s gap blk%0d valid=%0b done=%0b required 0/0", tag, b, valid_in, frame_done);
        end
        if (b >= 16) begin
          checks++;
          if (base_input_idx !== 9'(16 * (b - 16)) || input_real_a[15] !== t10(16 * (b - 16) + off + 15)) begin
            errs++;
            $display("FAIL %s gap_hold blk%0d base=%0d a_re15=%0d required %0d %0d", tag, b,
                     base_input_idx, input_real_a[15], 16 * (b - 16), 16 * (b - 16) + off + 15);
          end
        end
      end
    end
  endtask

  task automatic test_hold;
    set_blk(7);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
    checks++;
    if (valid_in !== 1'b0 || frame_done !== 1'b0 || base_input_idx !== 9'd240) begin
      errs++;
      $display("FAIL hold_ctrl valid=%0b done=%0b base=%0d required 0/0/240", valid_in, frame_done, base_input_idx);
    end
    checks++;
    if (input_real_a[15] !== 10'd255 || input_real_b[15] !== 10'd511 || input_imag_b[15] !== t10(-511)) begin
      errs++;
      $display("FAIL hold_data a_re15=%0d b_re15=%0d b_im15=%0d required 255 511 -511",
               input_real_a[15], input_real_b[15], input_imag_b[15]);
    end
  endtask

  task automatic test_back_to_back;
    test_frame("b2b_f1", 0, 1'b0);
    test_frame("b2b_f2", 100, 1'b0);
  endtask

  task automatic test_frame_clr;
    for (int b = 0; b <= 20; b++) begin
      set_blk(16 * b + 300);
      step(1'b1, 1'b0);
    end
    checks++;
    if (valid_in !== 1'b1 || base_input_idx !== 9'd64) begin
      errs++;
      $display("FAIL clr_pre valid=%0b base=%0d required 1/64", valid_in, base_input_idx);
    end
    // din_valid alongside frame_clr must be dropped.
    set_blk(400);
    step(1'b1, 1'b1);
    checks++;
    if (valid_in !== 1'b0 || frame_done !== 1'b0) begin
      errs++;
      $display("FAIL clr_force valid=%0b done=%0b required 0/0", valid_in, frame_done);
    end
    test_frame("after_clr", 50, 1'b0);
  endtask

  task automatic test_reset_mid;
    for (int b = 0; b <= 10; b++) begin
      set_blk(16 * b + 20);
      step(1'b1, 1'b0);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (valid_in !== 1'b0 || frame_done !== 1'b0 || base_input_idx !== 9'd0 ||
        input_real_a !== '0 || input_imag_a !== '0 || input_real_b !== '0 || input_imag_b !== '0) begin
      errs++;
      $display("FAIL reset_mid valid=%0b done=%0b base=%0d a_re0=%0d b_re0=%0d required all 0",
               valid_in, frame_done, base_input_idx, input_real_a[0], input_real_b[0]);
    end
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    test_frame("after_rst", 0, 1'b0);
  endtask

`ifdef BFLY01_FEEDER_FRAME_CNT_EN
  task automatic test_frame_cnt;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    checks++;
    if (frame_cnt !== 8'd0) begin
      errs++;
      $display("FAIL fcnt_reset got %0d required 0", frame_cnt);
    end
    for (int f = 0; f < 3; f++)
      for (int b = 0; b < 32; b++) begin
        set_blk(16 * b);
        step(1'b1, 1'b0);
      end
    checks++;
    if (frame_cnt !== 8'd3) begin
      errs++;
      $display("FAIL fcnt_3 got %0d required 3", frame_cnt);
    end
    step(1'b1, 1'b1);
    checks++;
    if (frame_cnt !== 8'd3) begin
      errs++;
      $display("FAIL fcnt_clr got %0d required 3", frame_cnt);
    end
    for (int f = 0; f < 253; f++)
      for (int b = 0; b < 32; b++) begin
        set_blk(16 * b);
        step(1'b1, 1'b0);
      end
    checks++;
    if (frame_cnt !== 8'd0) begin
      errs++;
      $display("FAIL fcnt_wrap got %0d required 0", frame_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_frame("full", 0, 1'b0);
    test_hold();
    test_frame("gaps", 0, 1'b1);
    test_back_to_back();
    test_frame_clr();
    test_reset_mid();
`ifdef BFLY01_FEEDER_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
